// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST sweep controller.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic MODE_EXH  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  localparam logic [15:0] DEF_MISR_POLY = 16'h1021;
  localparam logic [6:0]  DEF_PAT_POLY  = 7'h60;

endpackage

// File: rtl/bist_sweep_ctrl_if.sv
// Harness and netlist-side signals of the sweep controller.
// golden_sig/pass exist only when BIST_GOLDEN_CMP_EN is defined.
interface bist_sweep_ctrl_if #(
  parameter int NIN    = 7,
  parameter int NOUT   = 2,
  parameter int MISR_W = 16
);
  logic              start;
  logic              mode;
  logic              abort;
  logic [NIN-1:0]    pattern;
  logic [NOUT-1:0]   dut_resp;
  logic              busy;
  logic              done;
  logic [MISR_W-1:0] signature;
`ifdef BIST_GOLDEN_CMP_EN
  logic [MISR_W-1:0] golden_sig;
  logic              pass;

  modport master (
    output start, mode, abort, dut_resp, golden_sig,
    input  pattern, busy, done, signature, pass
  );
  modport slave (
    input  start, mode, abort, dut_resp, golden_sig,
    output pattern, busy, done, signature, pass
  );
`else
  modport master (
    output start, mode, abort, dut_resp,
    input  pattern, busy, done, signature
  );
  modport slave (
    input  start, mode, abort, dut_resp,
    output pattern, busy, done, signature
  );
`endif
endinterface

// File: rtl/bist_misr.sv
// Galois-form multiple-input signature register; clr wins over en.
module bist_misr
  import bist_pkg::*;
#(
  parameter int            W    = 16,
  parameter logic [W-1:0]  POLY = W'(DEF_MISR_POLY),
  parameter int            DW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [W-1:0]  sig
);

  logic [W-1:0] sig_nxt;

  always_comb begin
    sig_nxt = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ W'(din);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_nxt;
    end
  end

endmodule

// File: rtl/bist_sweep_ctrl.sv
// Pattern sweep sequencer feeding a combinational netlist and compacting its responses.
// Optional golden-signature comparator enabled by BIST_GOLDEN_CMP_EN.
//   state   | meaning
//   IDLE    | waiting for start, outputs hold
//   APPLY   | pattern driven, settle hold (SETTLE_CYC cycles)
//   CAPTURE | response folded into MISR, pattern advances
//   DONE    | sweep complete, signature stable
module bist_sweep_ctrl
  import bist_pkg::*;
#(
  parameter int                NIN        = 7,
  parameter int                NOUT       = 2,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = MISR_W'(DEF_MISR_POLY),
  parameter logic [NIN-1:0]    PAT_POLY   = NIN'(DEF_PAT_POLY),
  parameter int                SETTLE_CYC = 0
) (
  input  logic               clk,
  input  logic               rst,
  bist_sweep_ctrl_if.slave   bif
);

  localparam logic [NIN:0] LAST_EXH   = {1'b0, {NIN{1'b1}}};
  localparam logic [NIN:0] LAST_LFSR  = LAST_EXH - (NIN+1)'(1);
  localparam logic [3:0]   HOLD_LOAD  = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);
  localparam bit           HAS_SETTLE = (SETTLE_CYC != 0);

  state_t            state_q, state_d;
  logic              mode_q;
  logic [NIN-1:0]    pat_q, pat_nxt;
  logic [NIN:0]      pat_cnt_q, last_idx;
  logic [3:0]        hold_q;
  logic              start_ok, abort_ok, cap_en, last_pat;
  logic [MISR_W-1:0] sig;

  always_comb begin
    start_ok = bif.start && (state_q == IDLE || state_q == DONE);
    abort_ok = bif.abort && (state_q == APPLY || state_q == CAPTURE);
    cap_en   = (state_q == CAPTURE) && !bif.abort;
    last_idx = (mode_q == MODE_EXH) ? LAST_EXH : LAST_LFSR;
    last_pat = (pat_cnt_q == last_idx);
    pat_nxt  = (mode_q == MODE_LFSR) ? ((pat_q >> 1) ^ (pat_q[0] ? PAT_POLY : '0))
                                     : pat_q + 1'b1;
    state_d  = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (bif.start) state_d = HAS_SETTLE ? APPLY : CAPTURE;
      end
      APPLY: begin
        if (bif.abort)        state_d = IDLE;
        else if (hold_q == 0) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (bif.abort)   state_d = IDLE;
        else if (last_pat) state_d = DONE;
        else             state_d = HAS_SETTLE ? APPLY : CAPTURE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Settle hold is a down-counter reloaded whenever a new pattern goes out.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_EXH;
      pat_q     <= '0;
      pat_cnt_q <= '0;
      hold_q    <= '0;
    end else if (start_ok) begin
      mode_q    <= bif.mode;
      pat_q     <= (bif.mode == MODE_LFSR) ? NIN'(1) : '0;
      pat_cnt_q <= '0;
      hold_q    <= HOLD_LOAD;
    end else if (cap_en) begin
      pat_q     <= pat_nxt;
      pat_cnt_q <= last_pat ? '0 : pat_cnt_q + 1'b1;
      hold_q    <= HOLD_LOAD;
    end else if (state_q == APPLY && hold_q != 0) begin
      hold_q    <= hold_q - 1'b1;
    end
  end

  bist_misr #(
    .W    (MISR_W),
    .POLY (MISR_POLY),
    .DW   (NOUT)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (cap_en),
    .din (bif.dut_resp),
    .sig (sig)
  );

  assign bif.pattern   = pat_q;
  assign bif.busy      = (state_q == APPLY) || (state_q == CAPTURE);
  assign bif.done      = (state_q == DONE);
  assign bif.signature = sig;

`ifdef BIST_GOLDEN_CMP_EN
  // Compare the value the MISR is about to take so pass lands with DONE.
  logic              pass_q;
  logic [MISR_W-1:0] sig_fin;

  always_comb begin
    sig_fin = {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : '0) ^ MISR_W'(bif.dut_resp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= 1'b0;
    end else if (start_ok || abort_ok) begin
      pass_q <= 1'b0;
    end else if (cap_en && last_pat) begin
      pass_q <= (sig_fin == bif.golden_sig);
    end
  end

  assign bif.pass = pass_q;
`endif

endmodule

// File: tb/tb_bist_sweep_ctrl.sv
// Scoreboard bench for bist_sweep_ctrl: two instances (SETTLE_CYC 0 and 2), one active at a time.
// Honours BIST_GOLDEN_CMP_EN for the pass/golden_sig checks.
module tb_bist_sweep_ctrl;
  import bist_pkg::*;

  localparam int NIN  = 7;
  localparam int NOUT = 2;
  localparam int W    = 16;
  localparam logic [W-1:0]   MPOLY = 16'h1021;
  localparam logic [NIN-1:0] PPOLY = 7'h60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          rst_r, start_r, mode_r, abort_r;
  logic [1:0]          busy_w, done_w;
  logic [1:0][NIN-1:0] pat_w;
  logic [1:0][W-1:0]   sig_w;
`ifdef BIST_GOLDEN_CMP_EN
  logic [1:0][W-1:0]   golden_r;
  logic [1:0]          pass_w;
`endif

  int              resp_sel = 0;
  logic [NOUT-1:0] noise = '0;
  logic [NOUT-1:0] tbl [0:127];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0]   sig;
    logic [NIN-1:0] fin;
    int             nbusy;
    int             ndist;
    logic           pass;
  } res_t;

  logic [NIN-1:0] exp_pat_q[$];
  res_t           exp_res_q[$];
  int             act = 0, bcnt = 0, nbusy = 0, settle = 0;
  bit             seen [0:127];
  logic           done_prev = 1'b0;
  logic [W-1:0]   model_sig, sig2;
  logic [NIN-1:0] mon_ep;
  res_t           mon_r;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    bist_sweep_ctrl_if #(.NIN(NIN), .NOUT(NOUT), .MISR_W(W)) bif ();

    assign bif.start    = start_r[g];
    assign bif.mode     = mode_r[g];
    assign bif.abort    = abort_r[g];
    assign bif.dut_resp = noise ^ ((resp_sel == 0) ? '0 :
                                   (resp_sel == 1) ? bif.pattern[NOUT-1:0] : tbl[bif.pattern]);
    assign busy_w[g]    = bif.busy;
    assign done_w[g]    = bif.done;
    assign pat_w[g]     = bif.pattern;
    assign sig_w[g]     = bif.signature;
`ifdef BIST_GOLDEN_CMP_EN
    assign bif.golden_sig = golden_r[g];
    assign pass_w[g]      = bif.pass;
`endif

    bist_sweep_ctrl #(
      .NIN        (NIN),
      .NOUT       (NOUT),
      .MISR_W     (W),
      .MISR_POLY  (MPOLY),
      .PAT_POLY   (PPOLY),
      .SETTLE_CYC (2 * g)
    ) dut (
      .clk (clk),
      .rst (rst_r[g]),
      .bif (bif)
    );
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [NOUT-1:0] resp_of(input logic [NIN-1:0] p);
    if (resp_sel == 0) return '0;
    if (resp_sel == 1) return p[NOUT-1:0];
    return tbl[p];
  endfunction

  function automatic logic [W-1:0] misr_step(input logic [W-1:0] s, input logic [NOUT-1:0] r);
    return (s << 1) ^ (s[W-1] ? MPOLY : '0) ^ W'(r);
  endfunction

  function automatic logic [NIN-1:0] lfsr_next(input logic [NIN-1:0] p);
    return (p >> 1) ^ (p[0] ? PPOLY : '0);
  endfunction

  // Model the whole sweep up front, then issue the start.
  task automatic launch(input int g, input logic m);
    logic [NIN-1:0] p;
    logic [W-1:0]   s;
    res_t           r;
    int             npat;
    npat = m ? 127 : 128;
    p    = m ? NIN'(1) : '0;
    s    = '0;
    for (int i = 0; i < npat; i++) begin
      for (int k = 0; k <= 2 * g; k++) exp_pat_q.push_back(p);
      s = misr_step(s, resp_of(p));
      p = m ? lfsr_next(p) : p + 1'b1;
    end
    r.sig   = s;
    r.fin   = p;
    r.nbusy = npat * (2 * g + 1);
    r.ndist = npat;
`ifdef BIST_GOLDEN_CMP_EN
    r.pass  = (s == golden_r[g]);
`else
    r.pass  = 1'b0;
`endif
    exp_res_q.push_back(r);
    model_sig = s;
    @(posedge clk); #1;
    act       = g;
    settle    = 2 * g;
    bcnt      = 0;
    nbusy     = 0;
    for (int i = 0; i < 128; i++) seen[i] = 1'b0;
    done_prev = done_w[g];
    start_r[g] = 1'b1;
    mode_r[g]  = m;
    @(posedge clk); #1;
    start_r[g] = 1'b0;
    mode_r[g]  = 1'($urandom);
`ifdef BIST_GOLDEN_CMP_EN
    chk("pass_clear_on_start", {31'b0, pass_w[g]}, 32'd0);
`endif
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done_w[act] && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done_w[act]) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no done within %0d cycles", limit);
    end
    @(negedge clk); #1;
  endtask

  task automatic flush();
    exp_pat_q.delete();
    exp_res_q.delete();
  endtask

  // Monitor: pattern stream every busy cycle, result bundle on done rise.
  always @(negedge clk) begin
    if (busy_w[act]) begin
      noise = ((bcnt % (settle + 1)) != settle) ? NOUT'($urandom) : '0;
      bcnt++;
      nbusy++;
      if (exp_pat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pattern_stream: busy with pattern %0h but none expected", pat_w[act]);
      end else begin
        mon_ep = exp_pat_q.pop_front();
        chk("pattern", 32'(pat_w[act]), 32'(mon_ep));
      end
      seen[pat_w[act]] = 1'b1;
    end else begin
      noise = '0;
    end
    if (done_w[act] && !done_prev) begin
      if (exp_res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: done rose with no sweep expected");
      end else begin
        int nd;
        nd    = 0;
        mon_r = exp_res_q.pop_front();
        for (int i = 0; i < 128; i++) nd += int'(seen[i]);
        chk("signature", 32'(sig_w[act]), 32'(mon_r.sig));
        chk("final_pattern", 32'(pat_w[act]), 32'(mon_r.fin));
        chk("busy_cycles", nbusy, mon_r.nbusy);
        chk("distinct_patterns", nd, mon_r.ndist);
        chk("leftover_patterns", exp_pat_q.size(), 32'd0);
`ifdef BIST_GOLDEN_CMP_EN
        chk("pass_at_done", {31'b0, pass_w[act]}, {31'b0, mon_r.pass});
`endif
      end
    end
    done_prev = done_w[act];
  end

  initial begin
    int n;
    for (int i = 0; i < 128; i++) tbl[i] = NOUT'($urandom);
    rst_r   = 2'b11;
    start_r = '0;
    mode_r  = '0;
    abort_r = '0;
`ifdef BIST_GOLDEN_CMP_EN
    golden_r = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("reset_pattern", 32'(pat_w[g]), 32'd0);
      chk("reset_signature", 32'(sig_w[g]), 32'd0);
      chk("reset_busy", {31'b0, busy_w[g]}, 32'd0);
      chk("reset_done", {31'b0, done_w[g]}, 32'd0);
`ifdef BIST_GOLDEN_CMP_EN
      chk("reset_pass", {31'b0, pass_w[g]}, 32'd0);
`endif
    end
    rst_r = 2'b00;

    // zero responses, exhaustive
    resp_sel = 0;
    launch(0, 1'b0);
    wait_done(1000);
    chk("sig_zero_resp", 32'(sig_w[0]), 32'(model_sig));
    @(posedge clk); #1;
    abort_r[0] = 1'b1;
    @(posedge clk); #1;
    abort_r[0] = 1'b0;
    chk("abort_ignored_in_done", {31'b0, done_w[0]}, 32'd1);

    // pattern[1:0] responses, exhaustive
    resp_sel = 1;
    launch(0, 1'b0);
    wait_done(1000);
    sig2 = model_sig;

    // LFSR with random netlist table
    resp_sel = 2;
    launch(0, 1'b1);
    wait_done(1000);

    // settle instance, noisy responses during APPLY
    resp_sel = 1;
    launch(1, 1'b0);
    wait_done(1000);
    resp_sel = 2;
    launch(1, 1'b1);
    wait_done(1000);

    // start while busy ignored, then abort (with a coincident start)
    resp_sel = 2;
    launch(0, 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    start_r[0] = 1'b1;
    mode_r[0]  = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    n = $urandom_range(5, 40);
    repeat (n) begin @(posedge clk); #1; end
    abort_r[0] = 1'b1;
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    abort_r[0] = 1'b0;
    start_r[0] = 1'b0;
    flush();
    chk("abort_busy", {31'b0, busy_w[0]}, 32'd0);
    chk("abort_done", {31'b0, done_w[0]}, 32'd0);
    @(posedge clk); #1;
    chk("abort_stays_idle", {31'b0, busy_w[0]}, 32'd0);
    abort_r[0] = 1'b1;
    @(posedge clk); #1;
    abort_r[0] = 1'b0;
    launch(0, 1'b1);
    wait_done(1000);

    // synchronous reset mid-sweep
    resp_sel = 1;
    launch(1, 1'b0);
    n = $urandom_range(20, 200);
    repeat (n) begin @(posedge clk); #1; end
    rst_r[1] = 1'b1;
    @(posedge clk); #1;
    flush();
    chk("midrst_pattern", 32'(pat_w[1]), 32'd0);
    chk("midrst_signature", 32'(sig_w[1]), 32'd0);
    chk("midrst_busy", {31'b0, busy_w[1]}, 32'd0);
    chk("midrst_done", {31'b0, done_w[1]}, 32'd0);
`ifdef BIST_GOLDEN_CMP_EN
    chk("midrst_pass", {31'b0, pass_w[1]}, 32'd0);
`endif
    rst_r[1] = 1'b0;

    // random sweeps
    for (int it = 0; it < 3; it++) begin
      resp_sel = $urandom_range(0, 2);
      launch(int'($urandom_range(0, 1)), 1'($urandom));
      wait_done(1000);
    end

`ifdef BIST_GOLDEN_CMP_EN
    resp_sel    = 1;
    golden_r[0] = sig2;
    launch(0, 1'b0);
    wait_done(1000);
    chk("pass_golden_match", {31'b0, pass_w[0]}, 32'd1);
    golden_r[0] = sig2 ^ (W'(1) << $urandom_range(0, W - 1));
    launch(0, 1'b0);
    wait_done(1000);
    chk("pass_golden_flip", {31'b0, pass_w[0]}, 32'd0);
    golden_r[0] = sig2;
    launch(0, 1'b0);
    wait_done(1000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
